// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display blocks.
// Pure declarations; no logic.
package seg_pkg;

    localparam int         NUM_DIGITS = 6;
    localparam logic [5:0] SEL_OFF    = 6'b111111;
    localparam logic [7:0] SEG_OFF    = 8'hFF;

    typedef struct packed {
        logic       dp;
        logic [3:0] val;
    } digit_t;

    typedef enum logic {
        PH_DEAD,
        PH_SHOW
    } phase_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low 7-segment pattern (bit6..0 = g..a).
// Purely combinational, zero latency; no flow control.
module seg_hex_decode (
    input  logic [3:0] hex_val,
    output logic [6:0] seg_pat
);

    always_comb begin
        seg_pat = 7'h7F;
        case (hex_val)
            4'h0: seg_pat = 7'h40;
            4'h1: seg_pat = 7'h79;
            4'h2: seg_pat = 7'h24;
            4'h3: seg_pat = 7'h30;
            4'h4: seg_pat = 7'h19;
            4'h5: seg_pat = 7'h12;
            4'h6: seg_pat = 7'h02;
            4'h7: seg_pat = 7'h78;
            4'h8: seg_pat = 7'h00;
            4'h9: seg_pat = 7'h10;
            4'hA: seg_pat = 7'h08;
            4'hB: seg_pat = 7'h03;
            4'hC: seg_pat = 7'h46;
            4'hD: seg_pat = 7'h21;
            4'hE: seg_pat = 7'h06;
            4'hF: seg_pat = 7'h0E;
            default: seg_pat = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed 7-seg scanner with shadow buffer committed at frame boundaries.
// Outputs registered, one cycle after the cnt/idx/active state they reflect.
// Write port always ready one cycle after reset release; writes never stall.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEAD_CYC = 500
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_idx,
    input  logic [4:0] wr_data,
    input  logic [5:0] digit_en,
    output logic [5:0] sel,
    output logic [7:0] seg_led,
    output logic       frame_pulse
);

    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    digit_t        shadow [NUM_DIGITS];
    digit_t        active [NUM_DIGITS];
    logic          dirty;

    logic          slot_end;
    logic          frame_end;
    logic          wr_hit;
    phase_t        phase;
    digit_t        cur_digit;
    logic          cur_en;
    logic [6:0]    hex_pat;
    logic [5:0]    sel_nxt;
    logic [7:0]    seg_nxt;

    assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == 3'd5);
    assign wr_hit    = wr_valid && wr_ready && (wr_idx <= 3'd5);
    assign phase     = (cnt < CW'(DEAD_CYC)) ? PH_DEAD : PH_SHOW;

    // Explicit mux keeps the 3-bit idx from ever addressing past the six digits.
    always_comb begin
        cur_digit = '0;
        cur_en    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                cur_digit = active[i];
                cur_en    = digit_en[i];
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .hex_val (cur_digit.val),
        .seg_pat (hex_pat)
    );

    always_comb begin
        sel_nxt = SEL_OFF;
        seg_nxt = SEG_OFF;
        if (phase == PH_SHOW && cur_en) begin
            sel_nxt = SEL_OFF & ~(6'b000001 << idx);
            seg_nxt = {~cur_digit.dp, hex_pat};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            wr_ready    <= 1'b0;
            frame_pulse <= 1'b0;
            sel         <= SEL_OFF;
            seg_led     <= SEG_OFF;
        end else begin
            cnt         <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end
            wr_ready    <= 1'b1;
            frame_pulse <= frame_end;
            sel         <= sel_nxt;
            seg_led     <= seg_nxt;
        end
    end

    // Commit reads pre-edge shadow, so a coincident write survives in shadow and keeps dirty set.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            dirty <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (frame_end && dirty) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_hit) begin
                dirty <= 1'b1;
            end else if (frame_end) begin
                dirty <= 1'b0;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_hit && wr_idx == 3'(i)) begin
                    shadow[i] <= digit_t'(wr_data);
                end
            end
        end
    end

endmodule
